// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl - start/stop/pause timer with periodic and one-shot modes.
// Optional interrupt: TIMER_CTRL_IRQ_EN.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
`ifdef TIMER_CTRL_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_periodic;
  logic             w_term;

  assign w_term    = (r_count == r_period);
  assign tick      = (r_state == RUN) && w_term;
  assign busy      = (r_state == RUN) || (r_state == PAUSE);
  assign cfg_ready = (r_state == IDLE) || (r_state == DONE);
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_period   <= '0;
      r_periodic <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (cfg_valid) begin
            r_period   <= cfg_period;
            r_periodic <= cfg_periodic;
          end
          if (start && !stop) begin
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // The terminal condition wins over stop for the count update.
          if (w_term) begin
            if (r_periodic) begin
              r_count <= '0;
              r_state <= stop ? PAUSE : RUN;
            end else begin
              r_state <= DONE;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
            if (stop) r_state <= PAUSE;
          end
        end
        PAUSE: begin
          if (stop) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (start) begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq <= 1'b0;
    else if (tick)    irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl - scoreboard bench for timer_ctrl (WIDTH=8). Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_period = 8'd0;
  logic       cfg_periodic = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic       tick;
  logic [7:0] count;
`ifdef TIMER_CTRL_IRQ_EN
  logic       irq_clr = 1'b0;
  logic       irq;
`endif

  timer_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .tick         (tick),
`ifdef TIMER_CTRL_IRQ_EN
    .irq_clr      (irq_clr),
    .irq          (irq),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       ready;
    logic       irq;
    logic       chk_irq;
    string      name;
  } exp_t;

  exp_t q[$];
  event mon_ev;
  int   checks = 0;
  int   errors = 0;
  logic exp_irq = 1'b0;
  logic chk_irq = 1'b0;

  task automatic push(input logic [7:0] ec, input logic et, input logic eb,
                      input logic er, input string nm);
    exp_t e;
    e.count   = ec;
    e.tick    = et;
    e.busy    = eb;
    e.ready   = er;
    e.irq     = exp_irq;
    e.chk_irq = chk_irq;
    e.name    = nm;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs; expectation is the state seen after the edge.
  task automatic cyc(input logic st, input logic sp, input logic cv,
                     input logic [7:0] p, input logic m,
                     input logic [7:0] ec, input logic et, input logic eb,
                     input logic er, input string nm);
    start = st; stop = sp; cfg_valid = cv; cfg_period = p; cfg_periodic = m;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    push(ec, et, eb, er, nm);
  endtask

  task automatic run(input logic [7:0] ec, input logic et, input logic eb,
                     input logic er, input string nm);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, ec, et, eb, er, nm);
  endtask

  // Assert reset between edges and check the outputs before any edge arrives.
  task automatic do_reset(input string nm);
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_irq = 1'b0;
    #1;
    push(8'd0, 1'b0, 1'b0, 1'b1, nm);
    -> mon_ev;
    @(posedge clk); #1;
    push(8'd0, 1'b0, 1'b0, 1'b1, "rst_hold");
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({count, tick, busy, cfg_ready} !== {e.count, e.tick, e.busy, e.ready}) begin
          errors++;
          $display("FAIL %s: got count=%0d tick=%b busy=%b ready=%b, want count=%0d tick=%b busy=%b ready=%b",
                   e.name, count, tick, busy, cfg_ready, e.count, e.tick, e.busy, e.ready);
        end
`ifdef TIMER_CTRL_IRQ_EN
        if (e.chk_irq) begin
          checks++;
          if (irq !== e.irq) begin
            errors++;
            $display("FAIL %s_irq: got irq=%b, want irq=%b", e.name, irq, e.irq);
          end
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    do_reset("rst_init");

    // Periodic, P=3: 0,1,2,3(tick),0,...
    cyc(1, 0, 1, 8'd3, 1, 8'd0, 0, 1, 0, "per_start");
    run(8'd1, 0, 1, 0, "per_c1");
    run(8'd2, 0, 1, 0, "per_c2");
    run(8'd3, 1, 1, 0, "per_tick1");
    run(8'd0, 0, 1, 0, "per_wrap");
    run(8'd1, 0, 1, 0, "per_c1b");
    run(8'd2, 0, 1, 0, "per_c2b");
    run(8'd3, 1, 1, 0, "per_tick2");
    cyc(0, 1, 0, 8'd0, 0, 8'd0, 0, 1, 0, "stop_at_term");
    cyc(1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 1, "pause_start_stop");
    cyc(0, 1, 0, 8'd0, 0, 8'd0, 0, 0, 1, "idle_stop");

    // One-shot, P=5; cfg and start during RUN are ignored.
    cyc(1, 0, 1, 8'd5, 0, 8'd0, 0, 1, 0, "os_start");
    run(8'd1, 0, 1, 0, "os_c1");
    cyc(1, 0, 1, 8'd1, 1, 8'd2, 0, 1, 0, "os_run_cfg_start");
    run(8'd3, 0, 1, 0, "os_c3");
    run(8'd4, 0, 1, 0, "os_c4");
    run(8'd5, 1, 1, 0, "os_tick");
    run(8'd5, 0, 0, 1, "os_done");
    cyc(0, 1, 0, 8'd0, 0, 8'd5, 0, 0, 1, "done_stop");

    // Pause/resume from DONE with the same one-shot P=5.
    cyc(1, 0, 0, 8'd0, 0, 8'd0, 0, 1, 0, "pr_start");
    run(8'd1, 0, 1, 0, "pr_c1");
    run(8'd2, 0, 1, 0, "pr_c2");
    cyc(0, 1, 0, 8'd0, 0, 8'd3, 0, 1, 0, "pr_stop");
    for (int i = 0; i < 3; i++) run(8'd3, 0, 1, 0, "pr_hold");
    cyc(1, 0, 0, 8'd0, 0, 8'd3, 0, 1, 0, "pr_resume");
    run(8'd4, 0, 1, 0, "pr_c4");
    run(8'd5, 1, 1, 0, "pr_tick");
    run(8'd5, 0, 0, 1, "pr_done");

    // Async reset mid-run at count 7.
    cyc(1, 0, 1, 8'd20, 1, 8'd0, 0, 1, 0, "rst_run_start");
    for (int i = 1; i <= 7; i++) run(8'(i), 0, 1, 0, "rst_pre");
    do_reset("rst_async");
    // Reset leaves P=0 one-shot latched.
    cyc(1, 0, 0, 8'd0, 0, 8'd0, 1, 1, 0, "rst_p0_tick");
    run(8'd0, 0, 0, 1, "rst_oneshot_done");

    // P=0 periodic: tick every cycle.
    cyc(1, 0, 1, 8'd0, 1, 8'd0, 1, 1, 0, "p0_t0");
    for (int i = 0; i < 3; i++) run(8'd0, 1, 1, 0, "p0_tick");
    cyc(0, 1, 0, 8'd0, 0, 8'd0, 0, 1, 0, "p0_stop");
    cyc(0, 1, 0, 8'd0, 0, 8'd0, 0, 0, 1, "p0_idle");

    // Full range P=255 one-shot.
    cyc(1, 0, 1, 8'd255, 0, 8'd0, 0, 1, 0, "full_start");
    for (int i = 1; i <= 255; i++) run(8'(i), (i == 255), 1, 0, "full");
    run(8'd255, 0, 0, 1, "full_done");

`ifdef TIMER_CTRL_IRQ_EN
    do_reset("irq_rst");
    chk_irq = 1'b1;
    exp_irq = 1'b0;
    cyc(1, 0, 1, 8'd0, 0, 8'd0, 1, 1, 0, "irq_tick");
    irq_clr = 1'b1;
    exp_irq = 1'b1;
    run(8'd0, 0, 0, 1, "irq_set_wins");
    exp_irq = 1'b0;
    run(8'd0, 0, 0, 1, "irq_clr");
    irq_clr = 1'b0;
    chk_irq = 1'b0;
`endif

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
